// File: rtl/tbcm_crc_pkg.sv
// Shared CRC algorithm catalogue and helpers for the tbcm CRC blocks.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package tbcm_crc_pkg;

    // Widest CRC register the helpers can describe.
    localparam int unsigned CRC_MAX_WIDTH = 64;

    typedef logic [CRC_MAX_WIDTH-1:0] crc_word_t;

    typedef enum logic [2:0] {
        TBCM_CRC_8,
        TBCM_CRC_16_CCITT,
        TBCM_CRC_32,
        TBCM_CRC_32_BZIP2,
        TBCM_CRC_32_MPEG2
    } tbcm_crc_type;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } crc_state_t;

    function automatic int unsigned get_crc_width(tbcm_crc_type t);
        case (t)
            TBCM_CRC_8:        return 8;
            TBCM_CRC_16_CCITT: return 16;
            default:           return 32;
        endcase
    endfunction

    // Normal (MSB-first) polynomial with the implicit top bit dropped.
    function automatic crc_word_t get_crc_polynomial(tbcm_crc_type t);
        case (t)
            TBCM_CRC_8:        return crc_word_t'(8'h07);
            TBCM_CRC_16_CCITT: return crc_word_t'(16'h1021);
            default:           return crc_word_t'(32'h04C1_1DB7);
        endcase
    endfunction

    function automatic crc_word_t get_crc_init(tbcm_crc_type t);
        case (t)
            TBCM_CRC_8:        return crc_word_t'(8'h00);
            TBCM_CRC_16_CCITT: return crc_word_t'(16'hFFFF);
            default:           return crc_word_t'(32'hFFFF_FFFF);
        endcase
    endfunction

    function automatic crc_word_t get_crc_xor_out(tbcm_crc_type t);
        case (t)
            TBCM_CRC_32,
            TBCM_CRC_32_BZIP2: return crc_word_t'(32'hFFFF_FFFF);
            default:           return '0;
        endcase
    endfunction

    function automatic bit get_crc_reflect_in(tbcm_crc_type t);
        return (t == TBCM_CRC_32);
    endfunction

    function automatic bit get_crc_reflect_out(tbcm_crc_type t);
        return (t == TBCM_CRC_32);
    endfunction

    // Reverses the low 'width' bits of x; bits at and above 'width' come back as zero.
    function automatic crc_word_t reverse_bits(crc_word_t x, int unsigned width);
        crc_word_t r;
        r = '0;
        for (int i = 0; i < CRC_MAX_WIDTH; i++) begin
            if (i < width) begin
                r[width-1-i] = x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tbcm_crc_byte_step.sv
// Folds one byte into a CRC register value (MSB-first mod-2 division step).
// Latency: purely combinational.
// Backpressure: none; no handshake.
module tbcm_crc_byte_step
    import tbcm_crc_pkg::*;
#(
    parameter tbcm_crc_type         CRC_TYPE       = TBCM_CRC_32,
    parameter int unsigned          CRC_WIDTH      = get_crc_width(CRC_TYPE),
    parameter logic [CRC_WIDTH-1:0] CRC_POLYNOMIAL = CRC_WIDTH'(get_crc_polynomial(CRC_TYPE)),
    parameter bit                   REFLECT_IN     = get_crc_reflect_in(CRC_TYPE)
) (
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic [7:0]           data,
    output logic [CRC_WIDTH-1:0] crc_out
);

    logic [CRC_WIDTH-1:0] crc_v;
    logic [7:0]           byte_v;
    logic                 fb;

    // Shift the byte in one bit at a time, feedback taken from the register MSB,
    // so register widths below 8 or above the data width need no special casing.
    always_comb begin
        fb     = 1'b0;
        crc_v  = crc_in;
        byte_v = REFLECT_IN ? 8'(reverse_bits(crc_word_t'(data), 8)) : data;
        for (int i = 7; i >= 0; i--) begin
            fb    = crc_v[CRC_WIDTH-1] ^ byte_v[i];
            crc_v = (crc_v << 1) ^ (fb ? CRC_POLYNOMIAL : '0);
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/tbcm_crc_stream.sv
// Packet-aware streaming CRC: one beat per cycle in, one finalised CRC per packet out.
// Latency: result registered, visible the cycle after the last beat is accepted.
// Backpressure: o_ready drops only while a result is pending and i_crc_ready is low.
module tbcm_crc_stream
    import tbcm_crc_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH     = 32,
    parameter tbcm_crc_type         CRC_TYPE       = TBCM_CRC_32,
    parameter int unsigned          CRC_WIDTH      = get_crc_width(CRC_TYPE),
    parameter logic [CRC_WIDTH-1:0] CRC_POLYNOMIAL = CRC_WIDTH'(get_crc_polynomial(CRC_TYPE)),
    parameter logic [CRC_WIDTH-1:0] INIT_VALUE     = CRC_WIDTH'(get_crc_init(CRC_TYPE)),
    parameter logic [CRC_WIDTH-1:0] XOR_OUT        = CRC_WIDTH'(get_crc_xor_out(CRC_TYPE)),
    parameter bit                   REFLECT_IN     = get_crc_reflect_in(CRC_TYPE),
    parameter bit                   REFLECT_OUT    = get_crc_reflect_out(CRC_TYPE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic [((DATA_WIDTH/8) > 1 ? $clog2(DATA_WIDTH/8) : 1)-1:0] i_last_bytes,
    output logic                  o_crc_valid,
    input  logic                  i_crc_ready,
    output logic [CRC_WIDTH-1:0]  o_crc
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    crc_state_t           state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic                 crc_vld_d;
    logic [CRC_WIDTH-1:0] crc_dat_d;
    logic                 accept;
    logic [CRC_WIDTH-1:0] tap [NBYTES+1];
    logic [CRC_WIDTH-1:0] tap_last;
    logic [CRC_WIDTH-1:0] fin_crc;

    // Input side stalls only behind an unconsumed result; never depends on i_valid.
    assign o_ready = !o_crc_valid || i_crc_ready;
    assign accept  = i_valid && o_ready;

    // Byte chain: tap[k] is the running CRC after bytes 0..k-1 of this beat.
    assign tap[0] = crc_q;

    for (genvar k = 0; k < NBYTES; k++) begin : g_step
        tbcm_crc_byte_step #(
            .CRC_TYPE       (CRC_TYPE),
            .CRC_WIDTH      (CRC_WIDTH),
            .CRC_POLYNOMIAL (CRC_POLYNOMIAL),
            .REFLECT_IN     (REFLECT_IN)
        ) u_step (
            .crc_in  (tap[k]),
            .data    (i_data[8*k +: 8]),
            .crc_out (tap[k+1])
        );
    end

    // Pick the chain tap just past the last valid byte and finalise it.
    always_comb begin
        tap_last = tap[NBYTES];
        for (int k = 0; k < NBYTES; k++) begin
            if (k == int'(i_last_bytes)) begin
                tap_last = tap[k+1];
            end
        end
        fin_crc = (REFLECT_OUT ? CRC_WIDTH'(reverse_bits(crc_word_t'(tap_last), CRC_WIDTH))
                               : tap_last) ^ XOR_OUT;
    end

    // Next state: clear beats any beat; result handshake is independent of clear.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_vld_d = o_crc_valid;
        crc_dat_d = o_crc;
        if (o_crc_valid && i_crc_ready) begin
            crc_vld_d = 1'b0;
        end
        if (i_clear) begin
            state_d = ST_IDLE;
            crc_d   = INIT_VALUE;
        end else if (accept) begin
            if (i_last) begin
                state_d   = ST_IDLE;
                crc_d     = INIT_VALUE;
                crc_vld_d = 1'b1;
                crc_dat_d = fin_crc;
            end else begin
                state_d = ST_ACTIVE;
                crc_d   = tap[NBYTES];
            end
        end
    end

    // State, running CRC and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT_VALUE;
            o_crc_valid <= 1'b0;
            o_crc       <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            o_crc_valid <= crc_vld_d;
            o_crc       <= crc_dat_d;
        end
    end

endmodule

// File: tb/tb_tbcm_crc_stream.sv
module tb_tbcm_crc_stream;
    import tbcm_crc_pkg::*;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r_clear     [3];
    logic        r_valid     [3];
    logic [63:0] r_data      [3];
    logic        r_last      [3];
    logic [2:0]  r_lb        [3];
    logic        r_crc_ready [3];
    logic        w_ready     [3];
    logic        w_crc_valid [3];
    logic [31:0] w_crc       [3];
    logic        bz_ready, bz_vld, mp_ready, mp_vld;
    logic [31:0] bz_crc, mp_crc;

    int errors = 0;
    int checks = 0;

    tbcm_crc_stream #(.DATA_WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_clear(r_clear[0]), .i_valid(r_valid[0]), .o_ready(w_ready[0]),
        .i_data(r_data[0][7:0]), .i_last(r_last[0]), .i_last_bytes(r_lb[0][0:0]),
        .o_crc_valid(w_crc_valid[0]), .i_crc_ready(r_crc_ready[0]), .o_crc(w_crc[0]));

    tbcm_crc_stream #(.DATA_WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_clear(r_clear[1]), .i_valid(r_valid[1]), .o_ready(w_ready[1]),
        .i_data(r_data[1][31:0]), .i_last(r_last[1]), .i_last_bytes(r_lb[1][1:0]),
        .o_crc_valid(w_crc_valid[1]), .i_crc_ready(r_crc_ready[1]), .o_crc(w_crc[1]));

    tbcm_crc_stream #(.DATA_WIDTH(64)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_clear(r_clear[2]), .i_valid(r_valid[2]), .o_ready(w_ready[2]),
        .i_data(r_data[2]), .i_last(r_last[2]), .i_last_bytes(r_lb[2]),
        .o_crc_valid(w_crc_valid[2]), .i_crc_ready(r_crc_ready[2]), .o_crc(w_crc[2]));

    // BZIP2 and MPEG-2 variants share the 32-bit stimulus.
    tbcm_crc_stream #(.DATA_WIDTH(32), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)) u_bz (
        .i_clk(clk), .i_rst(rst), .i_clear(r_clear[1]), .i_valid(r_valid[1]), .o_ready(bz_ready),
        .i_data(r_data[1][31:0]), .i_last(r_last[1]), .i_last_bytes(r_lb[1][1:0]),
        .o_crc_valid(bz_vld), .i_crc_ready(r_crc_ready[1]), .o_crc(bz_crc));

    tbcm_crc_stream #(.DATA_WIDTH(32), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .XOR_OUT(32'h0)) u_mp (
        .i_clk(clk), .i_rst(rst), .i_clear(r_clear[1]), .i_valid(r_valid[1]), .o_ready(mp_ready),
        .i_data(r_data[1][31:0]), .i_last(r_last[1]), .i_last_bytes(r_lb[1][1:0]),
        .o_crc_valid(mp_vld), .i_crc_ready(r_crc_ready[1]), .o_crc(mp_crc));

    // Reference CRC-32: reflected register form, shifting right against the reversed polynomial.
    function automatic logic [31:0] ref_crc32(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Presents one beat on stream s and returns at posedge+1 after it was accepted.
    task automatic send_beat(input int s, input logic [63:0] d, input logic l,
                             input logic [2:0] lb, output bit ok);
        r_valid[s] = 1'b1;
        r_data[s]  = d;
        r_last[s]  = l;
        r_lb[s]    = lb;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (w_ready[s]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        r_valid[s] = 1'b0;
        r_last[s]  = 1'b0;
    endtask

    // "123456789" on the 32-bit stream, last beat word supplied by the caller.
    task automatic send_123(input logic [31:0] last_word, output bit ok);
        bit ok0, ok1, ok2;
        send_beat(1, 64'h3433_3231, 1'b0, 3'd0, ok0);
        send_beat(1, 64'h3837_3635, 1'b0, 3'd0, ok1);
        send_beat(1, {32'h0, last_word}, 1'b1, 3'd0, ok2);
        ok = ok0 && ok1 && ok2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (w_crc_valid[s] !== 1'b0) begin
                errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", s, w_crc_valid[s]);
            end
            checks++;
            if (w_crc[s] !== 32'h0) begin
                errors++; $display("FAIL reset_crc[%0d]: got %h expected 0", s, w_crc[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (w_ready[1] !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", w_ready[1]);
        end
    endtask

    task automatic test_check_value();
        bit ok;
        r_crc_ready[1] = 1'b1;
        send_123(32'h0000_0039, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL check_value_handshake: timeout expected accept"); end
        checks++;
        if (w_crc_valid[1] !== 1'b1) begin
            errors++; $display("FAIL check_value_valid: got %b expected 1", w_crc_valid[1]);
        end
        checks++;
        if (w_crc[1] !== 32'hCBF4_3926) begin
            errors++; $display("FAIL check_value_crc32: got %h expected cbf43926", w_crc[1]);
        end
        checks++;
        if (bz_crc !== 32'hFC89_1918) begin
            errors++; $display("FAIL check_value_bzip2: got %h expected fc891918", bz_crc);
        end
        checks++;
        if (mp_crc !== 32'h0376_E6E7) begin
            errors++; $display("FAIL check_value_mpeg2: got %h expected 0376e6e7", mp_crc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (w_crc_valid[1] !== 1'b0) begin
            errors++; $display("FAIL check_value_consumed: got %b expected 0", w_crc_valid[1]);
        end
    endtask

    task automatic test_partial_mask();
        bit ok;
        send_123(32'hDEAD_BE39, ok);
        checks++;
        if (!ok || w_crc[1] !== 32'hCBF4_3926) begin
            errors++; $display("FAIL partial_mask_crc32: got %h ok=%b expected cbf43926", w_crc[1], ok);
        end
        checks++;
        if (bz_crc !== 32'hFC89_1918) begin
            errors++; $display("FAIL partial_mask_bzip2: got %h expected fc891918", bz_crc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit ok, ok_a, ok_b;
        byte_q_t p2;
        logic [31:0] exp2;
        p2 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        exp2 = ref_crc32(p2);
        r_crc_ready[1] = 1'b0;
        send_123(32'h0000_0039, ok);
        fork
            begin
                send_beat(1, 64'h6463_6261, 1'b0, 3'd0, ok_a);
                send_beat(1, 64'hA5A5_6665, 1'b1, 3'd1, ok_b);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checks++;
                    if (w_ready[1] !== 1'b0) begin
                        errors++; $display("FAIL b2b_ready_low[%0d]: got %b expected 0", i, w_ready[1]);
                    end
                    checks++;
                    if (w_crc_valid[1] !== 1'b1 || w_crc[1] !== 32'hCBF4_3926) begin
                        errors++; $display("FAIL b2b_hold[%0d]: got vld=%b crc=%h expected 1 cbf43926",
                                           i, w_crc_valid[1], w_crc[1]);
                    end
                end
                @(posedge clk);
                #1;
                r_crc_ready[1] = 1'b1;
            end
        join
        checks++;
        if (!(ok && ok_a && ok_b)) begin errors++; $display("FAIL b2b_handshake: timeout expected accept"); end
        checks++;
        if (w_crc_valid[1] !== 1'b1 || w_crc[1] !== exp2) begin
            errors++; $display("FAIL b2b_second_crc: got vld=%b crc=%h expected 1 %h",
                               w_crc_valid[1], w_crc[1], exp2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        bit ok, ok1;
        r_crc_ready[1] = 1'b0;
        send_123(32'h0000_0039, ok);
        r_valid[1] = 1'b1; r_data[1] = 64'h1111_2222; r_clear[1] = 1'b1;
        @(posedge clk);
        #1;
        r_valid[1] = 1'b0; r_clear[1] = 1'b0;
        checks++;
        if (w_crc_valid[1] !== 1'b1 || w_crc[1] !== 32'hCBF4_3926) begin
            errors++; $display("FAIL clear_keeps_result: got vld=%b crc=%h expected 1 cbf43926",
                               w_crc_valid[1], w_crc[1]);
        end
        r_crc_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        send_beat(1, 64'h3433_3231, 1'b0, 3'd0, ok1);
        r_valid[1] = 1'b1; r_data[1] = 64'h3837_3635; r_last[1] = 1'b0; r_clear[1] = 1'b1;
        @(posedge clk);
        #1;
        r_valid[1] = 1'b0; r_clear[1] = 1'b0;
        send_123(32'h0000_0039, ok);
        checks++;
        if (!(ok && ok1) || w_crc_valid[1] !== 1'b1 || w_crc[1] !== 32'hCBF4_3926) begin
            errors++; $display("FAIL clear_resend_crc: got vld=%b crc=%h expected 1 cbf43926",
                               w_crc_valid[1], w_crc[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit ok, ok1;
        r_crc_ready[1] = 1'b0;
        send_123(32'h0000_0039, ok);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (w_crc_valid[1] !== 1'b0 || w_crc[1] !== 32'h0) begin
            errors++; $display("FAIL rst_async_result: got vld=%b crc=%h expected 0 0",
                               w_crc_valid[1], w_crc[1]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        r_crc_ready[1] = 1'b1;
        send_beat(1, 64'h3433_3231, 1'b0, 3'd0, ok1);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_123(32'h0000_0039, ok);
        checks++;
        if (!(ok && ok1) || w_crc[1] !== 32'hCBF4_3926) begin
            errors++; $display("FAIL rst_mid_packet_crc: got %h expected cbf43926", w_crc[1]);
        end
        @(posedge clk);
        #1;
    endtask

    // Random packets with random input gaps and result back-pressure on stream s.
    task automatic test_random_width(input int s, input int nb);
        logic [31:0] exp_q [$];
        int  n_pkts;
        int  got;
        bit  mon_done;
        n_pkts = 12;
        got = 0;
        mon_done = 1'b0;
        fork
            begin
                for (int p = 0; p < n_pkts; p++) begin
                    byte_q_t pkt;
                    int len;
                    len = $urandom_range(1, 64);
                    pkt = {};
                    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
                    exp_q.push_back(ref_crc32(pkt));
                    for (int base = 0; base < len; base += nb) begin
                        logic [63:0] d;
                        int  cnt;
                        bit  l, ok;
                        d = {$urandom, $urandom};
                        l = (len - base) <= nb;
                        cnt = l ? (len - base) : nb;
                        for (int k = 0; k < cnt; k++) d[8*k +: 8] = pkt[base+k];
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send_beat(s, d, l, 3'(cnt - 1), ok);
                        checks++;
                        if (!ok) begin
                            errors++; $display("FAIL random_handshake[w%0d]: timeout expected accept", nb * 8);
                        end
                    end
                end
            end
            begin
                int idle;
                idle = 0;
                while (got < n_pkts && idle < 2000) begin
                    @(negedge clk);
                    if (w_crc_valid[s] && r_crc_ready[s]) begin
                        idle = 0;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL random_extra[w%0d]: got %h expected none", nb * 8, w_crc[s]);
                        end else begin
                            if (w_crc[s] !== exp_q[0]) begin
                                errors++; $display("FAIL random_crc[w%0d] pkt %0d: got %h expected %h",
                                                   nb * 8, got, w_crc[s], exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                        end
                        got++;
                    end else begin
                        idle++;
                    end
                end
                checks++;
                if (got != n_pkts) begin
                    errors++; $display("FAIL random_count[w%0d]: got %0d results expected %0d", nb * 8, got, n_pkts);
                end
                mon_done = 1'b1;
            end
            begin
                while (!mon_done) begin
                    @(posedge clk);
                    #1;
                    r_crc_ready[s] = ($urandom_range(0, 3) != 0);
                end
                r_crc_ready[s] = 1'b1;
            end
        join
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_clear[i] = 1'b0; r_valid[i] = 1'b0; r_data[i] = '0;
            r_last[i] = 1'b0; r_lb[i] = '0; r_crc_ready[i] = 1'b1;
        end
        test_reset();
        test_check_value();
        test_partial_mask();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random_width(0, 1);
        test_random_width(1, 4);
        test_random_width(2, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tbcm_crc_stream.md
Name: tbcm_crc_stream

Overview:
- Streaming, packet-aware CRC engine for the tbcm component library.
- Accepts one DATA_WIDTH beat per cycle over a valid/ready handshake and folds every valid byte into a running CRC register. The last beat may be partial.
- On the last beat it produces one registered, finalised CRC through a second valid/ready handshake.
- Adds what the combinational per-word CRC lacks: multi-beat state, init value, input/output reflection, final XOR, partial last beat, abort and back-pressure.

Parameters:
- DATA_WIDTH, 32, beat width in bits; must be a multiple of 8 and at least 8.
- CRC_TYPE, TBCM_CRC_32, tbcm_crc_pkg algorithm selector.
- CRC_WIDTH, get_crc_width(CRC_TYPE), width of the CRC register.
- CRC_POLYNOMIAL, get_crc_polynomial(CRC_TYPE), normal (non-reflected) polynomial without the top bit.
- INIT_VALUE, get_crc_init(CRC_TYPE), register value at the start of each packet.
- XOR_OUT, get_crc_xor_out(CRC_TYPE), value XORed into the result.
- REFLECT_IN, get_crc_reflect_in(CRC_TYPE), 1 means each input byte is processed LSB first.
- REFLECT_OUT, get_crc_reflect_out(CRC_TYPE), 1 means the result is bit-reversed before XOR_OUT is applied.

Ports:
- i_clk  input  1  clock; the only clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_clear  input  1  synchronous abort of any packet in progress.
- i_valid  input  1  input beat valid.
- o_ready  output  1  input beat accepted when i_valid && o_ready.
- i_data  input  DATA_WIDTH  beat data; byte k is i_data[8k+7:8k], and byte 0 is first in the stream.
- i_last  input  1  beat is the last beat of the packet.
- i_last_bytes  input  max(1,$clog2(DATA_WIDTH/8))  number of valid bytes minus 1. Only meaningful with i_last; all bytes are valid when i_last=0.
- o_crc_valid  output  1  result valid.
- i_crc_ready  input  1  result consumed when o_crc_valid && i_crc_ready.
- o_crc  output  CRC_WIDTH  finalised CRC.

Behaviour:
- Reset: state=IDLE, crc_q=INIT_VALUE, o_crc_valid=0, o_crc=0. o_ready=1 once out of reset.
- Back-pressure: o_ready = !o_crc_valid || i_crc_ready. This is combinational, with no path from i_valid.
- FSM states:
  - IDLE: no packet open; crc_q=INIT_VALUE.
  - ACTIVE: packet open.
- Transitions:
  - Non-last beat accepted: crc_q <= update(crc_q, all bytes); state goes to ACTIVE.
  - Last beat accepted: crc_q <= INIT_VALUE and state goes to IDLE. In the same edge, o_crc <= finalise(update(crc_q, bytes 0..i_last_bytes)) and o_crc_valid <= 1.
- Latency: the result is visible on the cycle after the last beat is accepted. A single-beat packet is accepted in IDLE with no extra cycle.
- Throughput: one beat per cycle. Back-to-back packets run with no bubble while i_crc_ready=1.
- Byte update: bytes are folded sequentially in index order. When REFLECT_IN=1, each byte is bit-reversed before the MSB-first mod-2 step. Bytes above i_last_bytes on the last beat are ignored whatever their value.
- finalise(x) = (REFLECT_OUT ? reverse(x) : x) ^ XOR_OUT.
- Result handshake: o_crc and o_crc_valid are held stable until i_crc_ready. A new result may load on the same edge the old one is consumed.
- i_clear (highest priority below reset):
  - crc_q <= INIT_VALUE and state <= IDLE.
  - Any beat presented that cycle is dropped, even if the handshake fires.
  - A pending result is kept.
- Reset mid-packet or mid-result: everything returns to reset values immediately; the pending result is lost.
- CRC_WIDTH may be less than 8 or greater than DATA_WIDTH; the arithmetic must not assume otherwise.
- The update is combinational from the parameters. No tables are loaded at run time.

Decomposition:
- tbcm_crc_pkg gains:
  - get_crc_init, get_crc_xor_out, get_crc_reflect_in, get_crc_reflect_out per tbcm_crc_type.
  - A generic bit-reverse function.
- Sub-module tbcm_crc_byte_step: purely combinational, one byte into a CRC. It takes the same CRC parameters.
  - The top instantiates DATA_WIDTH/8 of these in a chain.
  - An output mux selects the chain tap at i_last_bytes.

Test Plan:
- CRC_32 defaults (reflect in/out, init and XOR_OUT all ones), DATA_WIDTH=32, input "123456789" as 0x34333231, 0x38373635, then 0x00000039 with last and i_last_bytes=0 -> o_crc=0xCBF43926 one cycle after the third beat.
- Same stream with REFLECT_IN=0, REFLECT_OUT=0 (BZIP2) -> 0xFC891918. With XOR_OUT=0 as well (MPEG-2) -> 0x0376E6E7.
- Partial-byte masking: repeat the default-parameter scenario with 0xDEADBE39 on the last beat -> still 0xCBF43926.
- Two back-to-back packets, i_crc_ready held low 3 cycles after the first result -> o_ready low exactly while o_crc_valid && !i_crc_ready. First CRC held stable, second packet CRC correct, no beat lost or duplicated.
- i_clear after beat 1 of "123456789", then full resend -> 0xCBF43926. i_rst asserted mid-packet -> o_crc_valid=0 and o_crc=0 asynchronously, and the next packet is correct.
- Random lengths 1..64 bytes, random valid/ready stalls, DATA_WIDTH in {8,32,64} -> every o_crc matches a bit-serial reference model.
